// File: rtl/lcd_pkg.sv
// Shared timing defaults, state encodings and helpers for the LCD read path.
package lcd_pkg;

    // Default bus timing in CCLK cycles (50 MHz)
    localparam int T_SETUP_DEF  = 16;
    localparam int T_EHIGH_DEF  = 32;
    localparam int T_HOLD_DEF   = 16;
    localparam int T_GAP_DEF    = 64;
    localparam int POLL_MAX_DEF = 131072;

    // Poll watchdog counter width
    localparam int POLL_W = 18;

    // Register-select encodings
    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    // Byte-level sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NIB_H,
        ST_GAP,
        ST_NIB_L,
        ST_FINISH
    } rd_state_e;

    // Single-nibble bus-cycle phases
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EHI,
        PH_HOLD
    } nib_phase_e;

    // Counter width able to hold 0..n-1 (at least one bit)
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_nibble_rd.sv
// One RW=1 nibble cycle: SETUP (E low), EHI (E high, sample on last cycle), HOLD (E low).
// Started by a one-cycle start pulse; fin is high on the final HOLD cycle.
module lcd_nibble_rd
    import lcd_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_EHIGH = T_EHIGH_DEF,
    parameter int T_HOLD  = T_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] lcdd_in,
    output logic       e,
    output logic       fin,
    output logic [3:0] nibble
);

    localparam int MAX_A = (T_SETUP > T_EHIGH) ? T_SETUP : T_EHIGH;
    localparam int MAX_T = (MAX_A > T_HOLD) ? MAX_A : T_HOLD;
    localparam int CNT_W = cnt_w(MAX_T);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] EHI_LAST   = CNT_W'(T_EHIGH - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);

    nib_phase_e       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       nib_q, nib_d;

    // Phase register and phase counter
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sampled nibble (data path, not reset)
    always_ff @(posedge clk) begin
        nib_q <= nib_d;
    end

    // Phase sequencing, nibble capture on the last E-high cycle
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        nib_d   = nib_q;
        fin     = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    phase_d = PH_SETUP;
                end
            end
            PH_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    phase_d = PH_EHI;
                    cnt_d   = '0;
                end
            end
            PH_EHI: begin
                if (cnt_q == EHI_LAST) begin
                    nib_d   = lcdd_in;
                    phase_d = PH_HOLD;
                    cnt_d   = '0;
                end
            end
            PH_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    fin     = 1'b1;
                    phase_d = PH_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                phase_d = PH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign e      = (phase_q == PH_EHI);
    assign nibble = nib_q;

endmodule

// File: rtl/lcd_reader.sv
// HD44780 4-bit read controller: fetches busy/address (RS=0) or RAM data (RS=1),
// optionally polling the busy flag until clear or until the watchdog expires.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_EHIGH  = T_EHIGH_DEF,
    parameter int T_HOLD   = T_HOLD_DEF,
    parameter int T_GAP    = T_GAP_DEF,
    parameter int POLL_MAX = POLL_MAX_DEF
) (
    input  logic       CCLK,
    input  logic       reset,
    input  logic       req,
    input  logic       rs_sel,
    input  logic       poll,
    input  logic [3:0] lcdd_in,
    output logic       rslcd,
    output logic       rwlcd,
    output logic       elcd,
    output logic       active,
    output logic       done,
    output logic [7:0] rdata,
    output logic       timeout
);

    localparam int                GAP_W    = cnt_w(T_GAP);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(T_GAP - 1);
    localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(POLL_MAX);
    localparam logic [POLL_W-1:0] POLL_SAT = '1;

    rd_state_e         state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic              rs_eff_q, rs_eff_d;
    logic              poll_q, poll_d;
    logic [3:0]        nib_h_q, nib_h_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic              nib_start;
    logic              nib_fin;
    logic              nib_e;
    logic [3:0]        nib_val;
    logic [7:0]        byte_w;
    logic              on_bus;

    lcd_nibble_rd #(
        .T_SETUP (T_SETUP),
        .T_EHIGH (T_EHIGH),
        .T_HOLD  (T_HOLD)
    ) u_nib (
        .clk     (CCLK),
        .rst     (reset),
        .start   (nib_start),
        .lcdd_in (lcdd_in),
        .e       (nib_e),
        .fin     (nib_fin),
        .nibble  (nib_val)
    );

    // Control state, counters and result registers
    always_ff @(posedge CCLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
            rs_eff_q   <= RS_CMD;
            poll_q     <= 1'b0;
            rdata_q    <= 8'h00;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            rs_eff_q   <= rs_eff_d;
            poll_q     <= poll_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    // Upper-nibble holding register (data path, not reset)
    always_ff @(posedge CCLK) begin
        nib_h_q <= nib_h_d;
    end

    // Byte sequencer: two nibble cycles separated by the gap, then result/poll decision
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        poll_cnt_d = poll_cnt_q;
        rs_eff_d   = rs_eff_q;
        poll_d     = poll_q;
        nib_h_d    = nib_h_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        nib_start  = 1'b0;
        byte_w     = {nib_h_q, nib_val};

        // Watchdog runs for the whole polled transaction and sticks at all-ones
        if (poll_q && (state_q != ST_IDLE) && (poll_cnt_q != POLL_SAT)) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                gap_cnt_d = '0;
                if (req) begin
                    rs_eff_d   = poll ? RS_CMD : rs_sel;
                    poll_d     = poll;
                    poll_cnt_d = '0;
                    nib_start  = 1'b1;
                    state_d    = ST_NIB_H;
                end
            end
            ST_NIB_H: begin
                if (nib_fin) begin
                    nib_h_d   = nib_val;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    nib_start = 1'b1;
                    state_d   = ST_NIB_L;
                end
            end
            ST_NIB_L: begin
                if (nib_fin) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                rdata_d = byte_w;
                if (poll_q && byte_w[7] && (poll_cnt_q < POLL_LIM)) begin
                    // Controller still busy: go straight into another status read
                    nib_start = 1'b1;
                    state_d   = ST_NIB_H;
                end else begin
                    done_d    = 1'b1;
                    timeout_d = poll_q & byte_w[7];
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign on_bus  = (state_q == ST_NIB_H) || (state_q == ST_GAP) || (state_q == ST_NIB_L);
    assign active  = on_bus;
    assign rwlcd   = on_bus;
    assign rslcd   = on_bus & rs_eff_q;
    assign elcd    = nib_e;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign rdata   = rdata_q;

endmodule
